// File: rtl/spi_flash_chip_erase_pkg.sv
// Shared types and constants for the one-shot SPI-flash chip-erase sequencer.
`timescale 1ns/1ps
package spi_ce_pkg;

   typedef enum logic [2:0] {WAIT, WREN, GAP, ERASE, DONE} state_t;
   typedef enum logic [1:0] {TX_IDLE, TX_LEAD, TX_BITS, TX_LAG} tx_phase_t;

   localparam logic [7:0] OPC_WREN = 8'h06;
   localparam logic [7:0] OPC_CE   = 8'hC7;

   localparam int CLK_DIV_DEF    = 4;
   localparam int START_WAIT_DEF = 10;
   localparam int CS_LEAD_DEF    = 4;
   localparam int CS_LAG_DEF     = 4;
   localparam int CS_GAP_DEF     = 5;

   // flash tPUW: 1 ms at 50 MHz
   localparam int PWRUP_CYCLES = 50_000;

   // bits needed for a counter that runs 0 .. n-1
   function automatic int cnt_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/spi_flash_chip_erase_if.sv
// Flash pin bundle driven by the chip-erase sequencer.
`timescale 1ns/1ps
interface spi_flash_chip_erase_if;
   logic spi_clk;
   logic cs;
   logic spi_mosi;

   modport master (output spi_clk, output cs, output spi_mosi);
   modport slave  (input  spi_clk, input  cs, input  spi_mosi);
endinterface

// File: rtl/spi_flash_chip_erase_byte_tx.sv
// Single-opcode SPI mode-0 frame generator: CS lead, 8 MSB-first bits, CS lag.
// phase   | meaning
// TX_IDLE | cs high, spi_clk low, mosi low, waiting for start
// TX_LEAD | cs low, spi_clk low, mosi = bit 7
// TX_BITS | shifting out bits, spi_clk high in second half of each bit
// TX_LAG  | cs low, spi_clk low; cs rises on the clock after the last lag clock
`timescale 1ns/1ps
module spi_ce_byte_tx
   import spi_ce_pkg::*;
#(
   parameter int CLK_DIV = CLK_DIV_DEF,
   parameter int CS_LEAD = CS_LEAD_DEF,
   parameter int CS_LAG  = CS_LAG_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] tx_byte,
   output logic       busy,
   output logic       last,
   output logic       cs,
   output logic       spi_clk,
   output logic       mosi
);

   localparam int TMR_MAX = (CS_LEAD > CLK_DIV) ? ((CS_LEAD > CS_LAG) ? CS_LEAD : CS_LAG)
                                                : ((CLK_DIV > CS_LAG) ? CLK_DIV : CS_LAG);
   localparam int TMR_W = cnt_width(TMR_MAX);

   localparam logic [TMR_W-1:0] LEAD_LD = TMR_W'(CS_LEAD - 1);
   localparam logic [TMR_W-1:0] DIV_LD  = TMR_W'(CLK_DIV - 1);
   localparam logic [TMR_W-1:0] LAG_LD  = TMR_W'(CS_LAG - 1);
   localparam logic [TMR_W-1:0] HALF    = TMR_W'(CLK_DIV / 2);

   tx_phase_t        phase_q, phase_d;
   logic [TMR_W-1:0] tmr_q, tmr_d, tmr_dec;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       sh_q, sh_d;
   logic             cs_q, cs_d;
   logic             sclk_q, sclk_d;
   logic             mosi_q, mosi_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q <= TX_IDLE;
         tmr_q   <= '0;
         bit_q   <= '0;
         sh_q    <= '0;
         cs_q    <= 1'b1;
         sclk_q  <= 1'b0;
         mosi_q  <= 1'b0;
      end else begin
         phase_q <= phase_d;
         tmr_q   <= tmr_d;
         bit_q   <= bit_d;
         sh_q    <= sh_d;
         cs_q    <= cs_d;
         sclk_q  <= sclk_d;
         mosi_q  <= mosi_d;
      end
   end

   always_comb begin
      phase_d = phase_q;
      tmr_d   = tmr_q;
      bit_d   = bit_q;
      sh_d    = sh_q;
      cs_d    = cs_q;
      sclk_d  = sclk_q;
      mosi_d  = mosi_q;
      tmr_dec = tmr_q - TMR_W'(1);
      unique case (phase_q)
         TX_IDLE: begin
            if (start) begin
               phase_d = TX_LEAD;
               tmr_d   = LEAD_LD;
               sh_d    = tx_byte;
               cs_d    = 1'b0;
               sclk_d  = 1'b0;
               mosi_d  = tx_byte[7];
            end
         end
         TX_LEAD: begin
            if (tmr_q == '0) begin
               phase_d = TX_BITS;
               tmr_d   = DIV_LD;
               bit_d   = 3'd7;
               mosi_d  = sh_q[7];
            end else begin
               tmr_d = tmr_dec;
            end
         end
         TX_BITS: begin
            // tmr counts down through the bit; the low half comes first
            if (tmr_q == '0) begin
               sclk_d = 1'b0;
               if (bit_q == '0) begin
                  phase_d = TX_LAG;
                  tmr_d   = LAG_LD;
               end else begin
                  bit_d  = bit_q - 3'd1;
                  sh_d   = {sh_q[6:0], 1'b0};
                  mosi_d = sh_q[6];
                  tmr_d  = DIV_LD;
               end
            end else begin
               tmr_d  = tmr_dec;
               sclk_d = (tmr_dec < HALF);
            end
         end
         TX_LAG: begin
            if (tmr_q == '0) begin
               phase_d = TX_IDLE;
               cs_d    = 1'b1;
               mosi_d  = 1'b0;
            end else begin
               tmr_d = tmr_dec;
            end
         end
         default: phase_d = TX_IDLE;
      endcase
   end

   assign busy    = (phase_q != TX_IDLE);
   assign last    = (phase_q == TX_LAG) && (tmr_q == '0);
   assign cs      = cs_q;
   assign spi_clk = sclk_q;
   assign mosi    = mosi_q;

endmodule

// File: rtl/spi_flash_chip_erase.sv
// One-shot SPI-flash bulk erase: WREN, CS gap, CHIP ERASE, then idle until reset.
// Build option SPI_CE_PWRUP_WAIT_EN stretches the post-reset wait to the flash power-up time.
// state | meaning
// WAIT  | counting the post-reset wait, pins idle
// WREN  | WRITE ENABLE frame in flight
// GAP   | cs held high between frames
// ERASE | CHIP ERASE frame in flight
// DONE  | finished, pins idle until next reset
`timescale 1ns/1ps
module spi_flash_chip_erase
   import spi_ce_pkg::*;
#(
   parameter int CLK_DIV    = CLK_DIV_DEF,
   parameter int START_WAIT = START_WAIT_DEF,
   parameter int CS_LEAD    = CS_LEAD_DEF,
   parameter int CS_LAG     = CS_LAG_DEF,
   parameter int CS_GAP     = CS_GAP_DEF
) (
   input  logic                   clk,
   input  logic                   rst_n,
   spi_flash_chip_erase_if.master spi
);

`ifdef SPI_CE_PWRUP_WAIT_EN
   localparam int WAIT_LEN = PWRUP_CYCLES;
`else
   localparam int WAIT_LEN = START_WAIT;
`endif

   localparam int CNT_W = cnt_width((WAIT_LEN > CS_GAP) ? WAIT_LEN : CS_GAP);
   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_LEN - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(CS_GAP - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tx_start;
   logic [7:0]       tx_byte;
   logic             tx_busy;
   logic             tx_last;
   logic             tx_cs;
   logic             tx_sclk;
   logic             tx_mosi;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= WAIT;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // start is issued in the cycle before cs must fall, so the wait and gap
   // lengths land exactly on the terminal count
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      tx_start = 1'b0;
      tx_byte  = OPC_WREN;
      unique case (state_q)
         WAIT: begin
            if (cnt_q == WAIT_LAST) begin
               if (!tx_busy) begin
                  tx_start = 1'b1;
                  state_d  = WREN;
                  cnt_d    = '0;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         WREN: begin
            if (tx_last) begin
               state_d = GAP;
               cnt_d   = '0;
            end
         end
         GAP: begin
            tx_byte = OPC_CE;
            if (cnt_q == GAP_LAST) begin
               if (!tx_busy) begin
                  tx_start = 1'b1;
                  state_d  = ERASE;
                  cnt_d    = '0;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ERASE: begin
            tx_byte = OPC_CE;
            if (tx_last) state_d = DONE;
         end
         DONE: state_d = DONE;
         default: state_d = WAIT;
      endcase
   end

   spi_ce_byte_tx #(
      .CLK_DIV (CLK_DIV),
      .CS_LEAD (CS_LEAD),
      .CS_LAG  (CS_LAG)
   ) u_byte_tx (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (tx_start),
      .tx_byte (tx_byte),
      .busy    (tx_busy),
      .last    (tx_last),
      .cs      (tx_cs),
      .spi_clk (tx_sclk),
      .mosi    (tx_mosi)
   );

   assign spi.cs       = tx_cs;
   assign spi.spi_clk  = tx_sclk;
   assign spi.spi_mosi = tx_mosi;

endmodule

// File: tb/tb_spi_flash_chip_erase.sv
// Scoreboard bench for spi_flash_chip_erase: frames decoded off the pins are checked against a cycle model.
`timescale 1ns/1ps
module tb_spi_flash_chip_erase;

   localparam int CLK_DIV = 4;
   localparam int CS_LEAD = 4;
   localparam int CS_LAG  = 4;
   localparam int CS_GAP  = 5;
`ifdef SPI_CE_PWRUP_WAIT_EN
   localparam int WAIT_CYC = 50_000;
`else
   localparam int WAIT_CYC = 10;
`endif
   localparam int FRAME  = CS_LEAD + 8 * CLK_DIV + CS_LAG;
   localparam int BUDGET = WAIT_CYC + 2000;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   spi_flash_chip_erase_if spi_if ();

   spi_flash_chip_erase #(
      .CLK_DIV    (CLK_DIV),
      .START_WAIT (10),
      .CS_LEAD    (CS_LEAD),
      .CS_LAG     (CS_LAG),
      .CS_GAP     (CS_GAP)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .spi   (spi_if)
   );

   always #10 clk = ~clk;

   typedef struct {
      logic [7:0] opc;
      int         rises;
      int         low_len;
   } frame_t;

   frame_t exp_q[$];
   int n_cmp  = 0;
   int n_fail = 0;
   int cyc    = 0;

   always @(posedge clk) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
      end
   endtask

   // reference timeline: frame k starts (cs falls) at cycle frame_start(k) after release
   function automatic int frame_start(input int k);
      return WAIT_CYC + k * (FRAME + CS_GAP);
   endfunction

   function automatic logic exp_cs(input int c);
      for (int k = 0; k < 2; k++)
         if (c - frame_start(k) >= 0 && c - frame_start(k) < FRAME) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic exp_sclk(input int c);
      int off;
      for (int k = 0; k < 2; k++) begin
         off = c - frame_start(k);
         if (off >= CS_LEAD && off < CS_LEAD + 8 * CLK_DIV)
            return ((off - CS_LEAD) % CLK_DIV) >= (CLK_DIV / 2);
      end
      return 1'b0;
   endfunction

   // monitor
   logic       prev_cs = 1'b1, prev_sclk = 1'b0, prev_mosi = 1'b0;
   logic       in_frame = 1'b0, seen_fall = 1'b0;
   logic [7:0] shreg = '0;
   int fall_cyc = 0, last_rise = 0, last_fall = 0, last_cs_rise = 0;
   int rises = 0, n_rise_tot = 0, n_falls = 0;
   frame_t f;

   always @(negedge clk) begin
      if (!rst_n) begin
         check("reset_outputs", {29'd0, spi_if.cs, spi_if.spi_clk, spi_if.spi_mosi}, 32'd4);
         in_frame   = 1'b0;
         seen_fall  = 1'b0;
         n_rise_tot = 0;
         n_falls    = 0;
         rises      = 0;
      end else begin
         if (spi_if.spi_clk) begin
            check("sclk_while_cs_high", {31'd0, spi_if.cs}, 32'd0);
            if (prev_sclk) check("mosi_stable_high", {31'd0, spi_if.spi_mosi}, {31'd0, prev_mosi});
         end
         if (prev_cs && !spi_if.cs) begin
            n_falls++;
            if (!seen_fall) check("first_cs_fall", cyc, WAIT_CYC);
            else            check("cs_gap", cyc - last_cs_rise, CS_GAP);
            seen_fall = 1'b1;
            in_frame  = 1'b1;
            fall_cyc  = cyc;
            rises     = 0;
            shreg     = '0;
         end
         if (!prev_sclk && spi_if.spi_clk && !spi_if.cs) begin
            if (rises == 0) check("cs_lead_to_rise", cyc - fall_cyc, CS_LEAD + CLK_DIV / 2);
            else            check("sclk_period", cyc - last_rise, CLK_DIV);
            shreg = {shreg[6:0], spi_if.spi_mosi};
            rises++;
            n_rise_tot++;
            last_rise = cyc;
         end
         if (prev_sclk && !spi_if.spi_clk) begin
            check("sclk_high_time", cyc - last_rise, CLK_DIV / 2);
            last_fall = cyc;
         end
         if (!prev_cs && spi_if.cs && in_frame) begin
            check("fall_to_cs_rise", cyc - last_fall, CS_LAG);
            if (exp_q.size() == 0) begin
               check("unexpected_frame", {24'd0, shreg}, 32'hFFFF_FFFF);
            end else begin
               f = exp_q.pop_front();
               check("frame_opcode", {24'd0, shreg}, {24'd0, f.opc});
               check("frame_rises", rises, f.rises);
               check("frame_cs_low", cyc - fall_cyc, f.low_len);
            end
            in_frame     = 1'b0;
            last_cs_rise = cyc;
         end
      end
      prev_cs   = spi_if.cs;
      prev_sclk = spi_if.spi_clk;
      prev_mosi = spi_if.spi_mosi;
   end

   // one reset/run; abort_c < 0 runs to DONE, otherwise reset is re-asserted at cycle abort_c
   task automatic run_seq(input bit first, input int abort_c);
      int budget;
      frame_t ef;
      if (first) begin
         #14 rst_n = 1'b1;
      end else begin
         rst_n = 1'b0;
         repeat ($urandom_range(1, 4)) @(posedge clk);
         @(negedge clk);
         #($urandom_range(1, 8));
         rst_n = 1'b1;
      end
      for (int k = 0; k < 2; k++) begin
         if (abort_c < 0 || frame_start(k) + FRAME < abort_c) begin
            ef.opc     = (k == 0) ? 8'h06 : 8'hC7;
            ef.rises   = 8;
            ef.low_len = FRAME;
            exp_q.push_back(ef);
         end
      end
      budget = 0;
      if (abort_c >= 0) begin
         while (cyc != abort_c && budget < BUDGET) begin
            @(posedge clk);
            #3;
            budget++;
         end
         check("abort_reached", {31'd0, budget < BUDGET}, 32'd1);
         check("pre_abort_cs", {31'd0, spi_if.cs}, {31'd0, exp_cs(abort_c)});
         check("pre_abort_sclk", {31'd0, spi_if.spi_clk}, {31'd0, exp_sclk(abort_c)});
         rst_n = 1'b0;
         #1;
         check("async_reset", {29'd0, spi_if.cs, spi_if.spi_clk, spi_if.spi_mosi}, 32'd4);
         @(negedge clk);
         check("abort_leftover", exp_q.size(), 0);
         exp_q.delete();
      end else begin
         while (exp_q.size() != 0 && budget < BUDGET) begin
            @(negedge clk);
            budget++;
         end
         check("frames_seen", exp_q.size(), 0);
         exp_q.delete();
         repeat (500) @(negedge clk);
         #1;
         check("total_rises", n_rise_tot, 16);
         check("cs_falls", n_falls, 2);
         check("done_idle", {29'd0, spi_if.cs, spi_if.spi_clk, spi_if.spi_mosi}, 32'd4);
      end
   endtask

   initial begin
      run_seq(1'b1, -1);
      run_seq(1'b0, frame_start(1) + CS_LEAD + 3 * CLK_DIV + CLK_DIV / 2);
      run_seq(1'b0, -1);
      for (int i = 0; i < 4; i++)
         run_seq(1'b0, int'($urandom_range(1, frame_start(1) + FRAME + 2)));
      run_seq(1'b0, -1);
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #(64'(BUDGET) * 20 * 12);
      $display("FAIL watchdog: run did not finish, got timeout expected completion");
      $fatal(1);
   end

endmodule
